// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and a word-wide data RAM with byte mask.
// Misaligned accesses are split into two RAM word accesses; one response per request.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_rdata,
  output logic                  ram_write_enable,
  output logic                  ram_read_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [3:0]            ram_mask,
  output logic [31:0]           ram_data_in,
  input  logic [31:0]           ram_data_out
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAcc0 = 3'd1;
  localparam logic [2:0] StAcc1 = 3'd2;
  localparam logic [2:0] StCap  = 3'd3;
  localparam logic [2:0] StResp = 3'd4;

  logic [2:0] state_q, state_d;

  logic                  write_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [31:0]           wdata_q;
  logic [1:0]            o_q;
  logic [ADDR_WIDTH-1:0] w0_q;
  logic                  mis_q;
  logic                  err_q;
  logic [31:0]           word0_q;
  logic [31:0]           word1_q;

  // Request decode, evaluated on the raw inputs only at accept time
  logic [31:0]           req_off;
  logic [1:0]            req_o;
  logic [3:0]            req_n;
  logic [ADDR_WIDTH-1:0] req_w0;
  logic                  req_mis;
  logic                  req_err;
  logic                  accept;

  always_comb begin
    req_off = req_addr - BASE_ADDR;
    req_o   = req_off[1:0];
    req_w0  = req_off[ADDR_WIDTH+1:2];
    unique case (req_size)
      2'b00:   req_n = 4'd1;
      2'b01:   req_n = 4'd2;
      default: req_n = 4'd4;
    endcase
    req_mis = ({2'b00, req_o} + req_n) > 4'd4;
    req_err = (req_size == 2'b11) || (|req_off[31:ADDR_WIDTH+2]) || (req_mis && (&req_w0));
  end

  assign accept = req_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid) state_d = req_err ? StResp : StAcc0;
      StAcc0: begin
        if (mis_q)        state_d = StAcc1;
        else if (write_q) state_d = StResp;
        else              state_d = StCap;
      end
      StAcc1:  state_d = write_q ? StResp : StCap;
      StCap:   state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers need no reset: they are only observed after being loaded
  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      write_q    <= req_write;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      wdata_q    <= req_wdata;
      o_q        <= req_o;
      w0_q       <= req_w0;
      mis_q      <= req_mis;
      err_q      <= req_err;
    end
    if (!write_q && state_q == StAcc1) begin
      word0_q <= ram_data_out;
    end
    if (!write_q && state_q == StCap) begin
      if (mis_q) word1_q <= ram_data_out;
      else       word0_q <= ram_data_out;
    end
  end

  // Lane mapping for stores
  logic [3:0]  n_mask;
  logic [7:0]  mask8;
  logic [63:0] data64;

  always_comb begin
    unique case (size_q)
      2'b00:   n_mask = 4'b0001;
      2'b01:   n_mask = 4'b0011;
      default: n_mask = 4'b1111;
    endcase
    mask8  = {4'b0000, n_mask} << o_q;
    data64 = {32'h0, wdata_q} << {o_q, 3'b000};
  end

  // Enables are gated by reset so a write in flight is dropped at the reset edge
  always_comb begin
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    ram_mask         = 4'b0000;
    ram_addr         = w0_q;
    ram_data_in      = data64[31:0];
    if (reset_n && state_q == StAcc0) begin
      ram_write_enable = write_q;
      ram_read_enable  = !write_q;
      ram_mask         = mask8[3:0];
    end else if (reset_n && state_q == StAcc1) begin
      ram_write_enable = write_q;
      ram_read_enable  = !write_q;
      ram_mask         = mask8[7:4];
      ram_addr         = w0_q + ADDR_WIDTH'(1);
      ram_data_in      = data64[63:32];
    end
  end

  // Load result extraction and extension
  logic [31:0] sel;
  logic [31:0] ext;

  always_comb begin
    sel = 32'({word1_q, word0_q} >> {o_q, 3'b000});
    unique case (size_q)
      2'b00:   ext = unsigned_q ? {24'h0, sel[7:0]} : {{24{sel[7]}}, sel[7:0]};
      2'b01:   ext = unsigned_q ? {16'h0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
      default: ext = sel;
    endcase
  end

  assign req_ready  = reset_n && (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_error = (state_q == StResp) && err_q;
  assign resp_rdata = ((state_q == StResp) && !err_q && !write_q) ? ext : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word RAM and hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] resp_rdata;
  logic        ram_write_enable;
  logic        ram_read_enable;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_mask;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  logic [31:0] mem [1024];

  int checks   = 0;
  int failures = 0;

  int          lat;
  logic        r_err;
  logic [31:0] r_data;
  logic        any_en;
  logic        tr_we   [1:8];
  logic        tr_re   [1:8];
  logic [9:0]  tr_addr [1:8];
  logic [3:0]  tr_mask [1:8];
  logic [31:0] tr_data [1:8];

  always #5 clk = ~clk;

  load_store_unit #(
    .ADDR_WIDTH(10),
    .BASE_ADDR (32'h0)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_error      (resp_error),
    .resp_rdata      (resp_rdata),
    .ram_write_enable(ram_write_enable),
    .ram_read_enable (ram_read_enable),
    .ram_addr        (ram_addr),
    .ram_mask        (ram_mask),
    .ram_data_in     (ram_data_in),
    .ram_data_out    (ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_write_enable) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_mask[b]) mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
      end
    end
    if (ram_read_enable) ram_data_out <= mem[ram_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and record the RAM trace until the response (at most 8 cycles)
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    @(negedge clk);
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'hFFFF_FFFF;
    lat    = 0;
    any_en = 1'b0;
    r_err  = 1'b0;
    r_data = 32'h0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      tr_we[k]   = ram_write_enable;
      tr_re[k]   = ram_read_enable;
      tr_addr[k] = ram_addr;
      tr_mask[k] = ram_mask;
      tr_data[k] = ram_data_in;
      if (ram_write_enable || ram_read_enable) any_en = 1'b1;
      if (resp_valid) begin
        lat    = k;
        r_err  = resp_error;
        r_data = resp_rdata;
      end
    end
  endtask

  task automatic check_resp(input string tag, input int exp_lat, input logic exp_err,
                            input logic [31:0] exp_data);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " error"}, {31'h0, r_err}, {31'h0, exp_err});
    check_eq({tag, " rdata"}, r_data, exp_data);
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = 1'b1;
    req_write    = 1'b1;
    req_addr     = 32'h0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n   = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("reset ready", {31'h0, req_ready}, 32'h1);
    check_eq("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("reset resp_error", {31'h0, resp_error}, 32'h0);
    check_eq("reset rdata", resp_rdata, 32'h0);
    check_eq("reset enables", {30'h0, ram_write_enable, ram_read_enable}, 32'h0);
    check_eq("reset mask", {28'h0, ram_mask}, 32'h0);

    // SB 0xAB @0x005
    do_req(1'b1, 32'h005, 2'b00, 1'b0, 32'h0000_00AB);
    check_eq("sb we", {31'h0, tr_we[1]}, 32'h1);
    check_eq("sb addr", {22'h0, tr_addr[1]}, 32'h1);
    check_eq("sb mask", {28'h0, tr_mask[1]}, 32'h2);
    check_eq("sb data", tr_data[1], 32'h0000_AB00);
    check_resp("sb", 2, 1'b0, 32'h0);

    // Word 1 = 0x80011234, then halfword/byte loads
    do_req(1'b1, 32'h004, 2'b10, 1'b0, 32'h8001_1234);
    check_resp("sw w1", 2, 1'b0, 32'h0);
    do_req(1'b0, 32'h006, 2'b01, 1'b0, 32'h0);
    check_eq("lh re", {31'h0, tr_re[1]}, 32'h1);
    check_eq("lh addr", {22'h0, tr_addr[1]}, 32'h1);
    check_resp("lh", 3, 1'b0, 32'hFFFF_8001);
    do_req(1'b0, 32'h006, 2'b01, 1'b1, 32'h0);
    check_resp("lhu", 3, 1'b0, 32'h0000_8001);
    do_req(1'b0, 32'h004, 2'b00, 1'b0, 32'h0);
    check_resp("lb", 3, 1'b0, 32'h0000_0034);

    // Misaligned SW @0x00B
    do_req(1'b1, 32'h00B, 2'b10, 1'b0, 32'h1122_3344);
    check_eq("msw acc0 addr", {22'h0, tr_addr[1]}, 32'h2);
    check_eq("msw acc0 mask", {28'h0, tr_mask[1]}, 32'h8);
    check_eq("msw acc0 data", {24'h0, tr_data[1][31:24]}, 32'h44);
    check_eq("msw acc1 we", {31'h0, tr_we[2]}, 32'h1);
    check_eq("msw acc1 addr", {22'h0, tr_addr[2]}, 32'h3);
    check_eq("msw acc1 mask", {28'h0, tr_mask[2]}, 32'h7);
    check_eq("msw acc1 data", tr_data[2], 32'h0011_2233);
    check_resp("msw", 3, 1'b0, 32'h0);

    // Misaligned LW @0x00B
    do_req(1'b0, 32'h00B, 2'b10, 1'b0, 32'h0);
    check_eq("mlw acc0 addr", {22'h0, tr_addr[1]}, 32'h2);
    check_eq("mlw acc1 addr", {22'h0, tr_addr[2]}, 32'h3);
    check_eq("mlw acc1 re", {31'h0, tr_re[2]}, 32'h1);
    check_resp("mlw", 4, 1'b0, 32'h1122_3344);

    // Error cases
    do_req(1'b0, 32'hFFE, 2'b10, 1'b0, 32'h0);
    check_resp("err last word", 1, 1'b1, 32'h0);
    check_eq("err last word no en", {31'h0, any_en}, 32'h0);
    do_req(1'b1, 32'h1000, 2'b10, 1'b0, 32'h1234_5678);
    check_resp("err range", 1, 1'b1, 32'h0);
    check_eq("err range no en", {31'h0, any_en}, 32'h0);
    do_req(1'b0, 32'h0, 2'b11, 1'b0, 32'h0);
    check_resp("err size", 1, 1'b1, 32'h0);
    check_eq("err size no en", {31'h0, any_en}, 32'h0);

    // Reset during ACC1 of a misaligned store
    do_req(1'b1, 32'h008, 2'b10, 1'b0, 32'h0);
    do_req(1'b1, 32'h00C, 2'b10, 1'b0, 32'h5555_5555);
    @(negedge clk);
    req_write = 1'b1;
    req_addr  = 32'h00B;
    req_size  = 2'b10;
    req_wdata = 32'hAABB_CCDD;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("rst acc0 we", {31'h0, ram_write_enable}, 32'h1);
    @(negedge clk);
    check_eq("rst acc1 addr", {22'h0, ram_addr}, 32'h3);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("rst ready", {31'h0, req_ready}, 32'h1);
      if (resp_valid) lat = 1;
    end
    check_eq("rst no resp", 32'(lat), 32'h0);
    check_eq("rst word2", mem[2], 32'hDD00_0000);
    check_eq("rst word3", mem[3], 32'h5555_5555);
    do_req(1'b0, 32'h00B, 2'b00, 1'b0, 32'h0);
    check_resp("lb after rst", 3, 1'b0, 32'hFFFF_FFDD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
